bcd_to_binary_seq: RTL and testbench
====================================

Name: bcd_to_binary_seq

Overview:
- Iterative BCD-to-binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is ≥8.
- Inverse of the binary-to-BCD display path.
- Converts user-entered timer values (BCD digits from the set/keypad logic) into binary counts for the countdown and count-up counters.
- Uses a start/busy/done handshake and is shared by both timer modes.

Parameters:
- DIGITS, 4, number of BCD digits at the input.
- BIN_W, 14, binary result width. Must satisfy 2^BIN_W > 10^DIGITS − 1 (14 bits covers 9999).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request. Sampled only when ready=1.
- bcd_in  input  4*DIGITS  packed BCD. Digit 0 is in bits [3:0].
- ready  output  1  high in IDLE; a start is accepted this cycle.
- busy  output  1  high while a conversion or invalid-report is in progress.
- done  output  1  one-cycle pulse when bin_out/invalid are updated.
- bin_out  output  BIN_W  converted value. Held until the next done.
- invalid  output  1  set with done if any input digit was >9. Held until the next done.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, ready=1, busy=0, done=0, bin_out=0, invalid=0, shift register and counter cleared.
- Reset takes priority over everything. Reset during SHIFT aborts the conversion with no done pulse.
- Working register: {bcd_reg[4*DIGITS-1:0], bin_reg[BIN_W-1:0]}, total width 4*DIGITS+BIN_W. Iteration counter is $clog2(BIN_W+1) bits.
- State IDLE:
  - ready=1, busy=0.
  - On start=1, check every digit of bcd_in.
  - Any digit >9: latch invalid flag, go to DONE. No shifting.
  - Otherwise: bcd_reg←bcd_in, bin_reg←0, cnt←0, go to SHIFT.
- State SHIFT (BIN_W cycles):
  - ready=0, busy=1.
  - Each cycle:
    - Shift the whole working register right by 1, with 0 entering the MSB.
    - Then, on the shifted value, replace each digit d with d−3 if d≥8. All digits are corrected in parallel, in the same cycle.
    - cnt←cnt+1.
  - When cnt reaches BIN_W−1 (the last shift), go to DONE.
- State DONE (1 cycle):
  - done=1, busy=1, ready=0.
  - bin_out←bin_reg, or 0 if invalid.
  - invalid←latched flag.
  - Next state IDLE.
- Latency:
  - Valid input: start accepted at edge N; done high during the cycle after edge N+BIN_W+1 (15 edges for BIN_W=14). bin_out is valid in that same cycle.
  - Invalid input: done one cycle after acceptance (edge N+1).
- start while ready=0 is ignored and not queued. start held high in the done cycle is also ignored. start held high on return to IDLE is accepted at the next edge, so back-to-back conversions are allowed.
- bcd_in is sampled only at acceptance. Later changes do not affect the result.
- Arithmetic:
  - Correction is 4-bit modulo. No digit can be ≥8 before correction except from a borrowed MSB, so the result stays within 0..9.
  - Any bits left in bcd_reg after BIN_W shifts are ignored. They are zero for legal inputs.
- Outputs are registered, with no combinational path from input to output, except ready, which decodes directly from state.

Decomposition:
- Shared package timer_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - constants BCD_CORR_THRESH=4'd8, BCD_CORR=4'd3, BCD_MAX_DIGIT=4'd9.
- Sub-module conditional_subtractor:
  - 4-bit combinational: out = (in ≥ 8) ? in − 3 : in.
  - Instantiated DIGITS times via generate on the post-shift digits.
  - Mirror of the add-3 cell in the binary-to-BCD path.
- FSM, counter and working register live in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles → ready=1, busy=0, done=0, bin_out=0, invalid=0.
- Zero input: start with bcd_in=16'h0000 → done at acceptance+15 edges, bin_out=0, invalid=0.
- Maximum input: start with 16'h9999 → bin_out=14'd9999 (0x270F), invalid=0, done is a single-cycle pulse. Also start with 16'h1234 → bin_out=1234 (0x4D2). Repeat back-to-back with start held high: both results are correct and done pulses are 16 cycles apart.
- Invalid digit: start with 16'h12A4 → done at acceptance+1, invalid=1, bin_out=0. A following start with 16'h0059 → bin_out=59, invalid=0.
- Start ignored when busy: start with 16'h0100, then pulse start with 16'h0999 at cycle 5 of SHIFT → only one done, bin_out=100.
- Reset mid-conversion: rst at cycle 7 of SHIFT → no done pulse, ready=1 on the next cycle, bin_out=0. A new start with 16'h0042 → bin_out=42.

Source files
------------

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer datapath: converter FSM states and the
// BCD digit constants used by the BCD <-> binary conversion cells.
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_CORR_THRESH = 4'd8;
    localparam logic [3:0] BCD_CORR        = 4'd3;
    localparam logic [3:0] BCD_MAX_DIGIT   = 4'd9;

    // True when a 4-bit field is not a legal decimal digit.
    function automatic logic digit_is_invalid(input logic [3:0] digit);
        return (digit > BCD_MAX_DIGIT);
    endfunction

endpackage : timer_pkg

// File: rtl/conditional_subtractor.sv
// -----------------------------------------------------------------------------
// conditional_subtractor
// One BCD digit correction cell for reverse double-dabble: after a right shift
// a digit that received a borrowed bit in its MSB reads 8 too high for a
// weight of 5, so 3 is removed. Mirror of the add-3 cell of binary-to-BCD.
// Ports:
//   digit_in  - post-shift BCD digit
//   digit_out - corrected digit (4-bit modulo arithmetic)
// -----------------------------------------------------------------------------
module conditional_subtractor
    import timer_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Subtract 3 when the digit is 8 or more, otherwise pass through.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_CORR_THRESH) begin
            digit_out = digit_in - BCD_CORR;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule : conditional_subtractor

// File: rtl/bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_seq
// Iterative BCD-to-binary converter (reverse double-dabble), one shift per
// clock, shared by the countdown and count-up timer modes.
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   start   - conversion request, sampled only while ready=1
//   bcd_in  - packed BCD input, digit 0 in bits [3:0]
//   ready   - high in IDLE (decoded from state)
//   busy    - high while a conversion or invalid report is under way
//   done    - single-cycle pulse when bin_out/invalid are updated
//   bin_out - converted value, held until the next done
//   invalid - input had a digit >9, held until the next done
// -----------------------------------------------------------------------------
module bcd_to_binary_seq
    import timer_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  invalid
);

    localparam int WORK_W = 4*DIGITS + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_r;
    logic [WORK_W-1:0]   work_r;        // {bcd_reg, bin_reg}
    logic [CNT_W-1:0]    cnt_r;
    logic                invalid_flag_r;
    logic                busy_r;
    logic                done_r;
    logic [BIN_W-1:0]    bin_out_r;
    logic                invalid_r;

    logic [WORK_W-1:0]   shifted_s;
    logic [WORK_W-1:0]   corrected_s;
    logic                any_invalid_s;

    // Right shift of the whole working register with zero entering the MSB.
    assign shifted_s = {1'b0, work_r[WORK_W-1:1]};

    // The binary half is never corrected; only the BCD digits are.
    assign corrected_s[BIN_W-1:0] = shifted_s[BIN_W-1:0];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : gen_corr
            conditional_subtractor u_corr (
                .digit_in  (shifted_s  [BIN_W + 4*g +: 4]),
                .digit_out (corrected_s[BIN_W + 4*g +: 4])
            );
        end
    endgenerate

    // Flag an input containing any non-decimal digit.
    always_comb begin
        any_invalid_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_is_invalid(bcd_in[4*i +: 4])) begin
                any_invalid_s = 1'b1;
            end else begin
                any_invalid_s = any_invalid_s;
            end
        end
    end

    // Converter FSM, iteration counter, working register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            work_r         <= {WORK_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            invalid_flag_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            bin_out_r      <= {BIN_W{1'b0}};
            invalid_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        invalid_flag_r <= any_invalid_s;
                        busy_r         <= 1'b1;
                        if (any_invalid_s) begin
                            // Nothing to shift; report straight away.
                            state_r <= DONE;
                        end else begin
                            work_r  <= {bcd_in, {BIN_W{1'b0}}};
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= SHIFT;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    work_r <= corrected_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    done_r    <= 1'b1;
                    bin_out_r <= invalid_flag_r ? {BIN_W{1'b0}} : work_r[BIN_W-1:0];
                    invalid_r <= invalid_flag_r;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = (state_r == IDLE);
    assign busy    = busy_r;
    assign done    = done_r;
    assign bin_out = bin_out_r;
    assign invalid = invalid_r;

endmodule : bcd_to_binary_seq

// File: tb/tb_bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_binary_seq
// Self-checking bench: table of {bcd, expected binary, expected invalid}
// vectors plus hand-written multi-cycle sequences. Expected results are
// queued when a start is driven and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_bcd_to_binary_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic        ready;
    logic        busy;
    logic        done;
    logic [13:0] bin_out;
    logic        invalid;

    bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .invalid (invalid)
    );

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] exp_bin;
        logic        exp_inv;
    } vec_t;

    typedef struct {
        logic [13:0] exp_bin;
        logic        exp_inv;
        int          exp_lat;
        int          acc_cyc;
        string       tag;
    } sb_t;

    sb_t  sb_q[$];
    int   done_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    vec_t vecs[13];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_log.push_back(cyc);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check({e.tag, "_bin"}, 32'(bin_out), 32'(e.exp_bin));
                check({e.tag, "_inv"}, 32'(invalid), 32'(e.exp_inv));
                check({e.tag, "_lat"}, 32'(cyc - e.acc_cyc - 1), 32'(e.exp_lat));
            end
        end
    end

    // Drive a one-cycle start from IDLE and queue its expected result.
    task automatic drive_one(input logic [15:0] v, input logic [13:0] eb, input logic ei,
                             input string tag);
        sb_t e;
        @(negedge clk);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        start  = 1'b1;
        bcd_in = v;
        e.exp_bin = eb;
        e.exp_inv = ei;
        e.exp_lat = ei ? 1 : 15;
        e.acc_cyc = cyc;
        e.tag     = tag;
        sb_q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'($urandom);   // must not disturb the conversion in flight
    endtask

    // Wait (bounded) for every queued result to appear.
    task automatic drain(input int max_cycles, input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        int n0;
        sb_t e;
        vecs[0]  = '{16'h0000, 14'd0,    1'b0};
        vecs[1]  = '{16'h9999, 14'd9999, 1'b0};
        vecs[2]  = '{16'h1234, 14'd1234, 1'b0};
        vecs[3]  = '{16'h12A4, 14'd0,    1'b1};
        vecs[4]  = '{16'h0059, 14'd59,   1'b0};
        vecs[5]  = '{16'h0001, 14'd1,    1'b0};
        vecs[6]  = '{16'h0010, 14'd10,   1'b0};
        vecs[7]  = '{16'h0900, 14'd900,  1'b0};
        vecs[8]  = '{16'h9000, 14'd9000, 1'b0};
        vecs[9]  = '{16'hF000, 14'd0,    1'b1};
        vecs[10] = '{16'h8765, 14'd8765, 1'b0};
        vecs[11] = '{16'h000A, 14'd0,    1'b1};
        vecs[12] = '{16'h5081, 14'd5081, 1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_ready",   32'(ready),   32'd1);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_bin",     32'(bin_out), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive_one(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_inv, $sformatf("vec%0d", i));
            drain(40, $sformatf("vec%0d", i));
        end

        // Back-to-back: start held high across two conversions.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h9999;
        n0 = done_log.size();
        e = '{14'd9999, 1'b0, 15, cyc, "b2b_first"};
        sb_q.push_back(e);
        @(negedge clk);
        bcd_in = 16'h1234;
        e = '{14'd1234, 1'b0, 15, cyc + 15, "b2b_second"};
        sb_q.push_back(e);
        repeat (16) @(negedge clk);
        start = 1'b0;
        drain(40, "b2b");
        if (done_log.size() >= n0 + 2)
            check("b2b_spacing", 32'(done_log[n0+1] - done_log[n0]), 32'd16);
        else
            check("b2b_done_count", 32'(done_log.size() - n0), 32'd2);

        // Start pulsed during SHIFT must be ignored.
        drive_one(16'h0100, 14'd100, 1'b0, "ignore");
        repeat (3) @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0999;
        @(negedge clk);
        start  = 1'b0;
        drain(40, "ignore");
        repeat (25) @(negedge clk);   // a queued 0999 would show as unexpected_done

        // Reset mid-conversion aborts without a done pulse.
        drive_one(16'h5555, 14'd5555, 1'b0, "abort");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("abort_ready", 32'(ready),   32'd1);
        check("abort_bin",   32'(bin_out), 32'd0);
        check("abort_done",  32'(done),    32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        drive_one(16'h0042, 14'd42, 1'b0, "after_abort");
        drain(40, "after_abort");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bcd_to_binary_seq
